counter_bus_reader: RTL and testbench
=====================================

Name: counter_bus_reader

Overview:
- Controller and reader at the far end of the 16-bit recycling counter's bus interface.
- Drives the counter's active-low count enable (n_CEN) and output enable (n_OE), and tracks recycles by edge-detecting REL.
- On request, freezes the counter, opens its tri-state output, samples Q, and presents a 32-bit extended count {recycles, Q} to downstream logic over a valid/ready handshake.

Parameters:
- N, 16'h000F, terminal count of the attached counter; the counter runs 0..N and recycles after N.
- SETTLE, 1, cycles n_OE is held low before Q is sampled (bus turn-on time); legal range 1..7.
- WRAP_W, 16, width of the recycle counter; data_out is {WRAP_W bits, 16 bits}.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- n_RESET  in  1  asynchronous reset, active low.
- run  in  1  level; 1 = let the counter count.
- snap_req  in  1  single-cycle pulse requesting a snapshot.
- clr  in  1  synchronous clear of the recycle counter and the ovf flag.
- Q  in  16  counter bus; high-Z whenever n_OE = 1.
- REL  in  1  counter recycle flag; high while count == 0.
- n_CEN  out  1  to counter; active-low count enable.
- n_OE  out  1  to counter; active-low output enable.
- data_out  out  WRAP_W+16  snapshot {wraps, Q}.
- valid  out  1  data_out is valid.
- ready  in  1  downstream accepts data_out.
- busy  out  1  high in any state other than IDLE or COUNT.
- ovf  out  1  sticky; recycle counter wrapped past all-ones.

Behaviour:
- Reset (asynchronous):
  - state = IDLE, n_CEN = 1, n_OE = 1, valid = 0, busy = 0, ovf = 0, data_out = 0, wraps = 0.
  - rel_q = 1, so the REL = 1 that follows a counter reset is not counted.
- Recycle tracking:
  - rel_rise = REL & ~rel_q; rel_q <= REL every cycle.
  - wraps increments on rel_rise in every state, including FREEZE, SETTLE and HOLD. The counter recycles at N even when n_CEN = 1.
  - wraps rolls over from all-ones to 0 and sets ovf.
  - clr sets wraps = 0 and ovf = 0. If clr and rel_rise occur in the same cycle, clr wins.
- States:
  - IDLE: n_CEN = 1, n_OE = 1. run = 1 -> COUNT. snap_req -> FREEZE.
  - COUNT: n_CEN = 0, n_OE = 1. snap_req -> FREEZE (takes priority over run = 0). run = 0 -> IDLE.
  - FREEZE: n_CEN = 1, n_OE = 1, one cycle; counter stops on the next edge. -> SETTLE.
  - SETTLE: n_CEN = 1, n_OE = 0 for SETTLE cycles (internal counter). At the last cycle, on that edge: data_out <= {wraps_next, Q}, where wraps_next includes this cycle's rel_rise; valid <= 1. -> HOLD.
  - HOLD: n_CEN = 1, n_OE = 0, valid = 1, data_out stable. On valid & ready: valid <= 0, n_OE <= 1; go to COUNT if run = 1, else IDLE.
- Ordering and boundary rules:
  - n_OE falls no earlier than one cycle after n_CEN rises. Q is never sampled while n_OE = 1.
  - snap_req outside IDLE/COUNT is ignored; there is no queueing.
  - ready while valid = 0 has no effect.
  - Latency: snap_req at edge k gives valid = 1 at edge k+2+SETTLE.
  - n_RESET low mid-snapshot: returns to IDLE at once; bus released (n_OE = 1), valid dropped.

Test Plan:
- Reset, then hold run = 1 for 37 counter increments, then pulse snap_req, hold ready = 1 -> n_CEN rises next edge; n_OE low 2 edges after snap_req; valid on edge k+3 with data_out = 0x0002_0005; one-cycle valid; returns to COUNT.
- Release from reset with REL = 1 and no counting -> wraps stays 0; a snapshot gives data_out = 0x0000_0000.
- Snapshot timed so the counter is at 15 during FREEZE -> counter recycles to 0 despite n_CEN = 1; data_out = {wraps+1, 0x0000}; REL edge counted exactly once.
- ready = 0 for 10 cycles in HOLD -> valid and data_out stable, n_OE = 0, n_CEN = 1 throughout; ready = 1 -> release in one cycle.
- Preload wraps = 0xFFFF, force one more REL rise -> wraps = 0x0000, ovf = 1 and stays 1; clr -> ovf = 0. clr coincident with a REL rise -> wraps = 0.
- Deassert n_RESET in SETTLE -> n_OE = 1, valid = 0, state IDLE in the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/counter_bus_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_bus_reader_if
//  Brief    : Bus between the reader, the recycling counter and the
//             downstream consumer: counter control/data plus a valid/ready
//             snapshot channel.
//  Revision : 1.0 - initial release
// ============================================================================
interface counter_bus_reader_if #(
  parameter int WRAP_W = 16
);
  logic [15:0]         Q;
  logic                REL;
  logic                n_CEN;
  logic                n_OE;
  logic [WRAP_W+15:0]  data_out;
  logic                valid;
  logic                ready;

  // Reader side: controls the counter and produces snapshots
  modport master (
    input  Q, REL, ready,
    output n_CEN, n_OE, data_out, valid
  );

  // Counter/consumer side
  modport slave (
    output Q, REL, ready,
    input  n_CEN, n_OE, data_out, valid
  );
endinterface
`default_nettype wire

// File: rtl/counter_bus_reader.sv
`default_nettype none
// ============================================================================
//  Module   : counter_bus_reader
//  Brief    : Controls a 16-bit recycling counter (count/output enables),
//             counts its recycles from REL rising edges, and on request
//             freezes it, samples Q and hands {wraps, Q} downstream over a
//             valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_bus_reader #(
  parameter logic [15:0] N      = 16'h000F,
  parameter int          SETTLE = 1,
  parameter int          WRAP_W = 16
) (
  input  wire logic            CLK,
  input  wire logic            n_RESET,
  input  wire logic            run,
  input  wire logic            snap_req,
  input  wire logic            clr,
  output logic                 busy,
  output logic                 ovf,
  counter_bus_reader_if.master bus
);

  // A counter with N = 0 keeps REL high forever, so recycles are invisible;
  // the settle counter is 3 bits wide.
  if (N == 16'h0000 || SETTLE < 1 || SETTLE > 7) begin : g_param_check
    $error("counter_bus_reader: N must be nonzero and SETTLE in 1..7");
  end

  localparam logic [2:0] c_SETTLE_LAST = 3'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_FREEZE = 3'd2,
    S_SETTLE = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2:0]          r_settle_cnt;
  logic                r_rel_q;
  logic [WRAP_W-1:0]   r_wraps;
  logic                r_ovf;
  logic [WRAP_W+15:0]  r_data;

  logic                w_rel_rise;
  logic                w_settle_last;
  logic [WRAP_W-1:0]   w_wraps_next;
  logic                w_n_cen;
  logic                w_n_oe;
  logic                w_valid;
  logic                w_busy;

  assign w_rel_rise    = bus.REL & ~r_rel_q;
  assign w_settle_last = (r_state == S_SETTLE) && (r_settle_cnt == c_SETTLE_LAST);

  // Next recycle count: clear dominates a coincident recycle edge
  always_comb begin
    w_wraps_next = r_wraps;
    if (clr) begin
      w_wraps_next = '0;
    end else if (w_rel_rise) begin
      w_wraps_next = r_wraps + 1'b1;
    end
  end

  // REL edge detector, recycle counter and sticky overflow; runs in every state
  // because the counter still recycles at N while frozen. rel_q resets high so
  // the REL that follows a counter reset is not counted.
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      r_rel_q <= 1'b1;
      r_wraps <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_rel_q <= bus.REL;
      r_wraps <= w_wraps_next;
      if (clr) begin
        r_ovf <= 1'b0;
      end else if (w_rel_rise && (&r_wraps)) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bus turn-on timer: counts cycles spent with n_OE low before sampling
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      r_settle_cnt <= '0;
    end else if (r_state == S_SETTLE) begin
      r_settle_cnt <= r_settle_cnt + 3'd1;
    end else begin
      r_settle_cnt <= '0;
    end
  end

  // Snapshot register; the recycle field includes a REL edge seen this cycle
  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      r_data <= '0;
    end else if (w_settle_last) begin
      r_data <= {w_wraps_next, bus.Q};
    end
  end

  // Next state and Moore outputs. FREEZE sits between COUNT and SETTLE so
  // n_OE never falls before the counter has seen n_CEN high for an edge.
  always_comb begin
    w_state_next = r_state;
    w_n_cen      = 1'b1;
    w_n_oe       = 1'b1;
    w_valid      = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (snap_req) begin
          w_state_next = S_FREEZE;
        end else if (run) begin
          w_state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        w_n_cen = 1'b0;
        if (snap_req) begin
          w_state_next = S_FREEZE;
        end else if (!run) begin
          w_state_next = S_IDLE;
        end
      end
      S_FREEZE: begin
        w_busy       = 1'b1;
        w_state_next = S_SETTLE;
      end
      S_SETTLE: begin
        w_busy = 1'b1;
        w_n_oe = 1'b0;
        if (w_settle_last) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        w_busy  = 1'b1;
        w_n_oe  = 1'b0;
        w_valid = 1'b1;
        if (bus.ready) begin
          w_state_next = run ? S_COUNT : S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.n_CEN    = w_n_cen;
  assign bus.n_OE     = w_n_oe;
  assign bus.valid    = w_valid;
  assign bus.data_out = r_data;
  assign busy         = w_busy;
  assign ovf          = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_counter_bus_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_bus_reader
//  Brief    : Directed bench for counter_bus_reader with a behavioural
//             recycling counter; a second small instance covers overflow.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_counter_bus_reader;

  localparam logic [15:0] c_N        = 16'h000F;
  localparam int          c_SETTLE_B = 3;

  logic CLK = 1'b0;
  logic n_RESET;
  logic run, snap_req, clr, ready_a;
  logic busy, ovf;
  logic snap_b, clr_b, ready_b, rel_b;
  logic busy_b, ovf_b;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  counter_bus_reader_if #(.WRAP_W(16)) bus_a ();
  counter_bus_reader_if #(.WRAP_W(4))  bus_b ();

  counter_bus_reader #(.N(c_N), .SETTLE(1), .WRAP_W(16)) dut (
    .CLK      (CLK),
    .n_RESET  (n_RESET),
    .run      (run),
    .snap_req (snap_req),
    .clr      (clr),
    .busy     (busy),
    .ovf      (ovf),
    .bus      (bus_a)
  );

  counter_bus_reader #(.N(c_N), .SETTLE(c_SETTLE_B), .WRAP_W(4)) dut_b (
    .CLK      (CLK),
    .n_RESET  (n_RESET),
    .run      (1'b0),
    .snap_req (snap_b),
    .clr      (clr_b),
    .busy     (busy_b),
    .ovf      (ovf_b),
    .bus      (bus_b)
  );

  // Behavioural recycling counter: counts 0..N while n_CEN is low, and
  // recycles from N to 0 even when frozen. An undriven bus reads as 0xDEAD.
  logic [15:0] cnt;
  int          inc_cnt;
  always @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      cnt     <= 16'h0000;
      inc_cnt <= 0;
    end else begin
      if (cnt == c_N) cnt <= 16'h0000;
      else if (!bus_a.n_CEN) cnt <= cnt + 16'd1;
      if (!bus_a.n_CEN) inc_cnt <= inc_cnt + 1;
    end
  end

  assign bus_a.REL   = (cnt == 16'h0000);
  assign bus_a.Q     = bus_a.n_OE ? 16'hDEAD : cnt;
  assign bus_a.ready = ready_a;
  assign bus_b.REL   = rel_b;
  assign bus_b.Q     = bus_b.n_OE ? 16'hDEAD : 16'h1234;
  assign bus_b.ready = ready_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Snapshot on the main instance with ready held high
  task automatic snap_a(input string tag, input logic [31:0] exp, input logic exp_ncen_after);
    snap_req = 1'b1;
    ready_a  = 1'b1;
    @(negedge CLK);
    snap_req = 1'b0;
    chk({tag, "_frz_ncen"}, 32'(bus_a.n_CEN), 32'd1);
    chk({tag, "_frz_noe"},  32'(bus_a.n_OE),  32'd1);
    chk({tag, "_frz_busy"}, 32'(busy),        32'd1);
    @(negedge CLK);
    chk({tag, "_set_noe"},   32'(bus_a.n_OE),  32'd0);
    chk({tag, "_set_ncen"},  32'(bus_a.n_CEN), 32'd1);
    chk({tag, "_set_valid"}, 32'(bus_a.valid), 32'd0);
    @(negedge CLK);
    chk({tag, "_valid"}, 32'(bus_a.valid), 32'd1);
    chk({tag, "_data"},  bus_a.data_out,   exp);
    @(negedge CLK);
    chk({tag, "_drop"},     32'(bus_a.valid), 32'd0);
    chk({tag, "_rel_noe"},  32'(bus_a.n_OE),  32'd1);
    chk({tag, "_aft_ncen"}, 32'(bus_a.n_CEN), 32'(exp_ncen_after));
    chk({tag, "_aft_busy"}, 32'(busy),        32'd0);
  endtask

  // Snapshot on the small instance, with bounded wait and latency check
  task automatic snap_bt(input string tag, input logic [19:0] exp);
    int lat;
    snap_b  = 1'b1;
    ready_b = 1'b1;
    @(negedge CLK);
    snap_b = 1'b0;
    lat    = 1;
    while (!bus_b.valid && lat < 12) begin
      @(negedge CLK);
      lat++;
    end
    chk({tag, "_lat"},  32'(lat),             32'(2 + c_SETTLE_B));
    chk({tag, "_data"}, 32'(bus_b.data_out),  32'(exp));
    chk({tag, "_ncen"}, 32'(bus_b.n_CEN),     32'd1);
    @(negedge CLK);
    chk({tag, "_drop"}, 32'(bus_b.valid),     32'd0);
  endtask

  task automatic pulse_rel_b(input int n);
    for (int i = 0; i < n; i++) begin
      rel_b = 1'b1;
      @(negedge CLK);
      rel_b = 1'b0;
      @(negedge CLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    n_RESET = 1'b0; run = 1'b0; snap_req = 1'b0; clr = 1'b0; ready_a = 1'b0;
    snap_b = 1'b0; clr_b = 1'b0; ready_b = 1'b0; rel_b = 1'b0;
    #1;
    chk("rst_ncen",  32'(bus_a.n_CEN),  32'd1);
    chk("rst_noe",   32'(bus_a.n_OE),   32'd1);
    chk("rst_valid", 32'(bus_a.valid),  32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_ovf",   32'(ovf),          32'd0);
    chk("rst_data",  bus_a.data_out,    32'd0);
    repeat (3) @(negedge CLK);
    n_RESET = 1'b1;

    // REL high straight out of reset must not be counted
    repeat (3) @(negedge CLK);
    snap_a("relrst", 32'h0000_0000, 1'b1);

    // 37 increments: two recycles, counter at 5
    run   = 1'b1;
    guard = 0;
    while (inc_cnt != 36 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    chk("run37_reach", 32'(inc_cnt), 32'd36);
    snap_a("run37", 32'h0002_0005, 1'b0);

    // Clear, then freeze with the counter landing on 15; hold ready low
    clr = 1'b1;
    @(negedge CLK);
    clr   = 1'b0;
    guard = 0;
    while (!(cnt == 16'd14 && bus_a.n_CEN == 1'b0) && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    chk("wrap_reach", 32'(cnt), 32'd14);
    snap_req = 1'b1;
    ready_a  = 1'b0;
    @(negedge CLK);
    snap_req = 1'b0;
    chk("wrap_frz_ncen", 32'(bus_a.n_CEN), 32'd1);
    @(negedge CLK);
    chk("wrap_set_noe", 32'(bus_a.n_OE), 32'd0);
    @(negedge CLK);
    chk("wrap_valid", 32'(bus_a.valid), 32'd1);
    chk("wrap_data",  bus_a.data_out,   32'h0001_0000);
    for (int i = 0; i < 10; i++) begin
      snap_req = (i == 0);
      @(negedge CLK);
      chk("hold_valid", 32'(bus_a.valid), 32'd1);
      chk("hold_data",  bus_a.data_out,   32'h0001_0000);
      chk("hold_noe",   32'(bus_a.n_OE),  32'd0);
      chk("hold_ncen",  32'(bus_a.n_CEN), 32'd1);
    end
    snap_req = 1'b0;
    ready_a  = 1'b1;
    @(negedge CLK);
    chk("hold_rel_valid", 32'(bus_a.valid), 32'd0);
    chk("hold_rel_noe",   32'(bus_a.n_OE),  32'd1);
    chk("hold_rel_ncen",  32'(bus_a.n_CEN), 32'd0);
    @(negedge CLK);
    chk("no_queue_busy", 32'(busy), 32'd0);

    // The recycle seen while frozen must have been counted exactly once
    guard = 0;
    while (!(cnt == 16'd3 && bus_a.n_CEN == 1'b0) && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    snap_a("once", 32'h0001_0004, 1'b0);

    // Asynchronous reset while in SETTLE
    snap_req = 1'b1;
    @(negedge CLK);
    snap_req = 1'b0;
    @(posedge CLK);
    #2;
    chk("rst_set_pre_noe", 32'(bus_a.n_OE), 32'd0);
    n_RESET = 1'b0;
    #1;
    chk("rst_set_noe",   32'(bus_a.n_OE),  32'd1);
    chk("rst_set_valid", 32'(bus_a.valid), 32'd0);
    chk("rst_set_busy",  32'(busy),        32'd0);
    chk("rst_set_ncen",  32'(bus_a.n_CEN), 32'd1);
    @(negedge CLK);
    n_RESET = 1'b1;
    run     = 1'b0;

    // Asynchronous reset while HOLD presents valid data
    @(negedge CLK);
    snap_req = 1'b1;
    ready_a  = 1'b0;
    @(negedge CLK);
    snap_req = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_hold_pre_valid", 32'(bus_a.valid), 32'd1);
    #2;
    n_RESET = 1'b0;
    #1;
    chk("rst_hold_valid", 32'(bus_a.valid), 32'd0);
    chk("rst_hold_noe",   32'(bus_a.n_OE),  32'd1);
    chk("rst_hold_data",  bus_a.data_out,   32'd0);
    @(negedge CLK);
    n_RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Overflow on the 4-bit recycle counter
    pulse_rel_b(15);
    chk("ovf_pre", 32'(ovf_b), 32'd0);
    snap_bt("wrapF", 20'hF_1234);
    rel_b = 1'b1;
    @(negedge CLK);
    rel_b = 1'b0;
    chk("ovf_set", 32'(ovf_b), 32'd1);
    repeat (5) @(negedge CLK);
    chk("ovf_sticky", 32'(ovf_b), 32'd1);
    snap_bt("wrap0", 20'h0_1234);
    clr_b = 1'b1;
    @(negedge CLK);
    clr_b = 1'b0;
    chk("ovf_clr", 32'(ovf_b), 32'd0);
    pulse_rel_b(3);
    rel_b = 1'b1;
    clr_b = 1'b1;
    @(negedge CLK);
    rel_b = 1'b0;
    clr_b = 1'b0;
    @(negedge CLK);
    snap_bt("clrwin", 20'h0_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
